sevenseg_scan: RTL

Time-multiplexed 4-digit seven-segment display driver. It sits directly downstream of the binary-to-BCD converter and consumes its thousand/hundred/ten/one nibbles. It snapshots the digits once per frame so the display never tears, scans one anode at a time with a guard gap against ghosting, and applies leading-zero blanking.

---
 rtl/sevenseg_scan_pkg.sv | 20 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/sevenseg_scan.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_pkg.sv
// rtl/sevenseg_scan_pkg.sv - shared seven-segment pattern constants
package sevenseg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-high segment decoder
module bcd_to_seg
  import sevenseg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Codes 10..15 show a dash so a bad upstream digit is visible, not blank
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - 4-digit multiplexed seven-segment scanner
// Per-frame digit snapshot, guard gap per slot and leading-zero blanking.
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            thousand,
  input  logic [3:0]            hundred,
  input  logic [3:0]            ten,
  input  logic [3:0]            one,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int                    CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]         CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         GUARD_C  = CW'(GUARD);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_IDLE = {7{ACTIVE_LOW}};

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [1:0]                    idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]    digit_q, digit_d;
  logic [NUM_DIGITS-1:0]         dp_shadow_q, dp_shadow_d;
  logic                          load_pending_q, load_pending_d;
  logic                          frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0]         an_q, an_d;
  logic [6:0]                    seg_q, seg_d;
  logic                          dp_q, dp_d;

  logic                          tick;
  logic                          frame_end;
  logic [NUM_DIGITS-1:0]         blank;
  logic [3:0]                    cur_digit;
  logic [6:0]                    dec_seg;
  logic                          slot_blank;
  logic                          in_guard;
  logic [NUM_DIGITS-1:0]         an_hi;
  logic [6:0]                    seg_hi;
  logic                          dp_hi;

  // Prescaler, scan index and frame snapshot
  always_comb begin
    tick           = (cnt_q == CNT_MAX);
    frame_end      = tick && (idx_q == 2'd3);
    cnt_d          = tick ? '0 : cnt_q + CW'(1);
    idx_d          = tick ? idx_q + 2'd1 : idx_q;
    load_pending_d = 1'b0;
    frame_tick_d   = frame_end;
    digit_d        = digit_q;
    dp_shadow_d    = dp_shadow_q;
    if (load_pending_q || frame_end) begin
      digit_d     = {thousand, hundred, ten, one};
      dp_shadow_d = dp_in;
    end
  end

  // A digit is a leading zero only if every more significant digit is also zero
  always_comb begin
    blank    = '0;
    blank[3] = BLANK_LZ && (digit_q[3] == 4'd0);
    blank[2] = blank[3] && (digit_q[2] == 4'd0);
    blank[1] = blank[2] && (digit_q[1] == 4'd0);
    blank[0] = 1'b0;
  end

  assign cur_digit = digit_q[idx_q];

  bcd_to_seg u_bcd_to_seg (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    slot_blank = blank[idx_q];
    in_guard   = (cnt_q < GUARD_C);
    an_hi      = (in_guard || slot_blank) ? '0 : (NUM_DIGITS'(1) << idx_q);
    seg_hi     = slot_blank ? SEG_OFF : dec_seg;
    dp_hi      = !slot_blank && dp_shadow_q[idx_q];
    an_d       = an_hi ^ AN_IDLE;
    seg_d      = seg_hi ^ SEG_IDLE;
    dp_d       = dp_hi ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      digit_q        <= '0;
      dp_shadow_q    <= '0;
      load_pending_q <= 1'b1;
      frame_tick_q   <= 1'b0;
      an_q           <= AN_IDLE;
      seg_q          <= SEG_IDLE;
      dp_q           <= ACTIVE_LOW;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      digit_q        <= digit_d;
      dp_shadow_q    <= dp_shadow_d;
      load_pending_q <= load_pending_d;
      frame_tick_q   <= frame_tick_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
